// File: rtl/video_system_cpu_debug_mem_sequencer_if.sv
// Bundle connecting the debug sequencer to the JTAG debug module and to the
// debug RAM's Avalon-MM slave port. The sequencer uses the master view.
interface video_system_cpu_debug_mem_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              cmd_overrun;

    modport master (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  avm_readdata, avm_waitrequest,
        output avm_address, avm_read, avm_write, avm_writedata,
        output MonDReg, monitor_ready, monitor_error, cmd_overrun
    );

    modport slave (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output avm_readdata, avm_waitrequest,
        input  avm_address, avm_read, avm_write, avm_writedata,
        input  MonDReg, monitor_ready, monitor_error, cmd_overrun
    );
endinterface

// File: rtl/video_system_cpu_debug_mem_sequencer.sv
// Turns debug-module action strobes into single-word OCI RAM accesses with an
// auto-incrementing address, a bounded waitrequest timeout and sticky status.
module video_system_cpu_debug_mem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    video_system_cpu_debug_mem_sequencer_if.master bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [31:0]       monDReg_q;
    logic              ready_q;
    logic              error_q;
    logic              overrun_q;
    logic              incPending_q;
    logic              timedOut_q;
    logic [CNT_W-1:0]  waitCnt_q;

    logic              anyStrobe;
    logic [ADDR_W-1:0] jdoAddr;
    logic [31:0]       jdoData;
    logic              unusedJdo;

    assign anyStrobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b
                     | bus.take_no_action_ocimem_a;
    assign jdoAddr   = bus.jdo[ADDR_W+1:2];
    assign jdoData   = bus.jdo[34:3];
    assign unusedJdo = ^{bus.jdo[37], bus.jdo[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            monDReg_q    <= '0;
            ready_q      <= 1'b1;
            error_q      <= 1'b0;
            overrun_q    <= 1'b0;
            incPending_q <= 1'b0;
            timedOut_q   <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.take_action_ocimem_a) begin
                        addr_q <= jdoAddr;
                        if (bus.jdo[36]) begin
                            error_q   <= 1'b0;
                            overrun_q <= 1'b0;
                        end
                        if (bus.jdo[35]) begin
                            state_q      <= RD;
                            read_q       <= 1'b1;
                            ready_q      <= 1'b0;
                            waitCnt_q    <= '0;
                            incPending_q <= 1'b0;
                        end
                    end else if (bus.take_action_ocimem_b) begin
                        wdata_q      <= jdoData;
                        monDReg_q    <= jdoData;
                        state_q      <= WR;
                        write_q      <= 1'b1;
                        ready_q      <= 1'b0;
                        waitCnt_q    <= '0;
                        incPending_q <= 1'b1;
                    end else if (bus.take_no_action_ocimem_a) begin
                        state_q      <= RD;
                        read_q       <= 1'b1;
                        ready_q      <= 1'b0;
                        waitCnt_q    <= '0;
                        incPending_q <= 1'b1;
                    end
                end
                RD, WR: begin
                    if (anyStrobe) begin
                        overrun_q <= 1'b1;
                    end
                    if (!bus.avm_waitrequest) begin
                        if (state_q == RD) begin
                            monDReg_q <= bus.avm_readdata;
                        end
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state_q <= DONE;
                    end else if (waitCnt_q == CNT_LAST) begin
                        // Abort: error is reported alongside ready in DONE
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        incPending_q <= 1'b0;
                        timedOut_q   <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (anyStrobe) begin
                        overrun_q <= 1'b1;
                    end
                    if (incPending_q) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (timedOut_q) begin
                        error_q <= 1'b1;
                    end
                    incPending_q <= 1'b0;
                    timedOut_q   <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.avm_address   = addr_q;
    assign bus.avm_read      = read_q;
    assign bus.avm_write     = write_q;
    assign bus.avm_writedata = wdata_q;
    assign bus.MonDReg       = monDReg_q;
    assign bus.monitor_ready = ready_q;
    assign bus.monitor_error = error_q;
    assign bus.cmd_overrun   = overrun_q;
endmodule

// File: doc/video_system_cpu_debug_mem_sequencer.md
# video_system_cpu_debug_mem_sequencer

System-clock-side sequencer that turns the JTAG debug module's decoded action strobes and `jdo` payload into single-word accesses on the CPU's on-chip debug memory (OCI RAM). It sits between the debug module's sysclk half and an Avalon-MM slave port on the debug RAM. It returns read data and status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug module for shifting back to the host. It owns the auto-incrementing address register, the access handshake and the timeout/error policy.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width of the debug RAM.
- `TIMEOUT`, 255: maximum `avm_waitrequest` cycles before an access is aborted. Must be at least 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  payload from the debug module; valid in the cycle of any strobe.
- `take_action_ocimem_a`  in  1  load address; optionally start a read.
- `take_action_ocimem_b`  in  1  write a data word, then post-increment the address.
- `take_no_action_ocimem_a`  in  1  read at the current address, then post-increment.
- `avm_address`  out  ADDR_W  word address to the debug RAM.
- `avm_read`  out  1  read request.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  read data; valid in the cycle `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`  in  1  slave stall.
- `MonDReg`  out  32  last read data, or last write data.
- `monitor_ready`  out  1  1 = idle and last operation complete.
- `monitor_error`  out  1  sticky; set on timeout.
- `cmd_overrun`  out  1  sticky; set when a strobe arrives while busy.

## Operation
- Reset values:
  - `avm_address`=0, `avm_read`=0, `avm_write`=0, `avm_writedata`=0.
  - `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `cmd_overrun`=0.
  - Timeout counter=0. State=IDLE.
- `jdo` decode:
  - address = `jdo[ADDR_W+1:2]`.
  - read-on-load flag = `jdo[35]`.
  - write data = `jdo[34:3]`.
  - clear-error flag = `jdo[36]`, honoured only on `take_action_ocimem_a`.
- Strobe priority when several are high in one cycle: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are ignored and do not set `cmd_overrun`.
- State machine:
  - IDLE, on `take_action_ocimem_a`:
    - Load address.
    - If `jdo[36]`, clear `monitor_error` and `cmd_overrun`.
    - If `jdo[35]`, go to RD with no post-increment; otherwise stay in IDLE.
  - IDLE, on `take_action_ocimem_b`:
    - Latch write data into `avm_writedata` and `MonDReg`.
    - Go to WR. Post-increment on completion.
  - IDLE, on `take_no_action_ocimem_a`: go to RD. Post-increment on completion.
  - Entering RD or WR: `monitor_ready`←0 and the timeout counter is cleared.
  - RD: `avm_read`=1.
    - When `avm_waitrequest`=0: `MonDReg`←`avm_readdata`, then go to DONE.
  - WR: `avm_write`=1.
    - When `avm_waitrequest`=0, go to DONE.
  - RD/WR while `avm_waitrequest`=1:
    - The counter increments each cycle.
    - When it reaches `TIMEOUT`: deassert the request, set `monitor_error`=1, leave `MonDReg` unchanged, skip post-increment, go to DONE.
  - DONE: apply post-increment if pending, set `monitor_ready`=1, return to IDLE. Lasts one cycle.
- Address arithmetic is modulo 2^ADDR_W. Increment from all-ones wraps to 0.
- A strobe in RD, WR or DONE is dropped and sets `cmd_overrun`=1. The in-flight access is unaffected.
- `avm_read` and `avm_write` are never asserted together. `avm_address` and `avm_writedata` stay stable while a request is asserted.
- `reset` mid-access: the request is deasserted the next cycle and all state returns to reset values. No completion is reported.

## Timing
- All outputs are registered.
- Strobe in cycle N → request asserted in cycle N+1.
- With `avm_waitrequest`=0 throughout:
  - Request lasts exactly 1 cycle (N+1).
  - DONE is cycle N+2.
  - `monitor_ready`=1 and `MonDReg` updated are visible in cycle N+3.
  - The incremented address is visible in cycle N+3.
- Each waitrequest cycle adds 1 cycle of latency.
- Timeout path: request held for `TIMEOUT` cycles, then dropped. `monitor_error` is visible 2 cycles after the request drops.
- Back-to-back throughput: one access per 3 cycles. A strobe in the cycle `monitor_ready` rises is accepted.

## Test plan
- Reset, then idle 5 cycles → every output at its reset value. No `avm_read` or `avm_write` asserted.
- Load address 0x10 (no read-on-load), then `take_action_ocimem_b` with data 0xDEADBEEF and zero waitrequest:
  - Write at 0x10 with data 0xDEADBEEF, request held 1 cycle.
  - `MonDReg`=0xDEADBEEF.
  - Address becomes 0x11 and `monitor_ready` is high 3 cycles after the strobe.
- Load address 0xFF with read-on-load, slave returns 0x12345678 after 3 waitrequest cycles:
  - `avm_read` high for 4 cycles at 0xFF.
  - `MonDReg`=0x12345678.
  - Address stays 0xFF because read-on-load does not increment.
  - A following `take_no_action_ocimem_a` reads 0xFF, then the address wraps to 0x00.
- `TIMEOUT`=4 with waitrequest stuck at 1:
  - Request held 4 cycles, then dropped.
  - `monitor_error`=1, address not incremented, `MonDReg` unchanged.
  - A later load with `jdo[36]`=1 clears `monitor_error`.
- Strobe issued during a stalled read → `cmd_overrun`=1. The original read completes with correct data, and exactly one access occurs.
- `take_action_ocimem_a` and `take_action_ocimem_b` in the same cycle → only the address load happens, no write is issued, and `cmd_overrun` stays 0. `reset` asserted mid-write → `avm_write`=0 the next cycle and all outputs return to reset values.
